// File: rtl/even_pipe.sv
// rtl/even_pipe.sv - Two-stage SIMD fixed-point even execution pipe.
// Define EVENPIPE_MULTIPLY_EN to add the 16x16 multiply family; otherwise those opcodes are NOPs.
package descriptions;
    typedef enum logic [6:0] {
        NOP, ADD_WORD, ADD_WORD_IMMEDIATE, SUBTRACT_FROM_WORD, SUBTRACT_FROM_WORD_IMMEDIATE,
        ADD_HALFWORD, ADD_HALFWORD_IMMEDIATE, SUBTRACT_FROM_HALFWORD, SUBTRACT_FROM_HALFWORD_IMMEDIATE,
        CARRY_GENERATE, BORROW_GENERATE,
        AND, AND_WITH_COMPLEMENT, OR, OR_COMPLEMENT, EXCLUSIVE_OR, NAND, NOR,
        AND_HALFWORD_IMMEDIATE, AND_WORD_IMMEDIATE, OR_HALFWORD_IMMEDIATE, OR_WORD_IMMEDIATE,
        EXCLUSIVE_OR_HALFWORD_IMMEDIATE, EXCLUSIVE_OR_WORD_IMMEDIATE,
        COMPARE_EQUAL_HALFWORD, COMPARE_EQUAL_HALFWORD_IMMEDIATE, COMPARE_EQUAL_WORD, COMPARE_EQUAL_WORD_IMMEDIATE,
        COMPARE_GREATER_THAN_HALFWORD, COMPARE_GREATER_THAN_HALFWORD_IMMEDIATE,
        COMPARE_GREATER_THAN_WORD, COMPARE_GREATER_THAN_WORD_IMMEDIATE,
        COMPARE_LOGICAL_GREATER_THAN_HALFWORD, COMPARE_LOGICAL_GREATER_THAN_HALFWORD_IMMEDIATE,
        COMPARE_LOGICAL_GREATER_THAN_WORD, COMPARE_LOGICAL_GREATER_THAN_WORD_IMMEDIATE,
        COUNT_LEADING_ZEROS, FORM_SELECT_MASK_FOR_HALFWORDS, FORM_SELECT_MASK_FOR_WORDS,
        IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_HALFWORD_UPPER, IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_ADDRESS,
        SHIFT_LEFT_HALFWORD, SHIFT_LEFT_HALFWORD_IMMEDIATE, SHIFT_LEFT_WORD, SHIFT_LEFT_WORD_IMMEDIATE,
        ROTATE_HALFWORD, ROTATE_HALFWORD_IMMEDIATE, ROTATE_WORD, ROTATE_WORD_IMMEDIATE,
        MULTIPLY, MULTIPLY_UNSIGNED, MULTIPLY_IMMEDIATE, MULTIPLY_UNSIGNED_IMMEDIATE, MULTIPLY_AND_ADD,
        FLOATING_MULTIPLY, LOAD_QUADWORD
    } opcode;
endpackage

module even_pipe import descriptions::*; #(
    parameter int LATENCY = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  opcode        ep_input_op_code,
    input  logic [127:0] ra_input,
    input  logic [127:0] rb_input,
    input  logic [127:0] rc_input,
    input  logic [6:0]   rt_address_input,
    input  logic [6:0]   I7_input,
    input  logic [9:0]   I10_input,
    input  logic [15:0]  I16_input,
    input  logic [17:0]  I18_input,
    output logic [127:0] rt_value_output,
    output logic [6:0]   rt_address_output,
    output logic         wrt_en_output
);

    function automatic logic [5:0] f_clz(input logic [31:0] a);
        f_clz = 6'd32;
        for (int k = 0; k < 32; k++)
            if (a[k]) f_clz = 6'(31 - k);
    endfunction

    // Returns {supported, result} for one 32-bit word; MULTIPLY_AND_ADD's rc term is added by the caller.
    function automatic logic [32:0] f_word(input opcode op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] s, input logic [15:0] i16,
                                           input logic [17:0] i18, input logic [5:0] i7);
        logic [5:0] cnt;
        cnt = (op == SHIFT_LEFT_WORD_IMMEDIATE || op == ROTATE_WORD_IMMEDIATE) ? i7 : b[5:0];
        case (op)
            ADD_WORD:                      f_word = {1'b1, a + b};
            ADD_WORD_IMMEDIATE:            f_word = {1'b1, a + s};
            SUBTRACT_FROM_WORD:            f_word = {1'b1, b - a};
            SUBTRACT_FROM_WORD_IMMEDIATE:  f_word = {1'b1, s - a};
            CARRY_GENERATE:                f_word = {1'b1, 31'd0, a > ~b};
            BORROW_GENERATE:               f_word = {1'b1, 31'd0, b >= a};
            AND:                           f_word = {1'b1, a & b};
            AND_WITH_COMPLEMENT:           f_word = {1'b1, a & ~b};
            OR:                            f_word = {1'b1, a | b};
            OR_COMPLEMENT:                 f_word = {1'b1, a | ~b};
            EXCLUSIVE_OR:                  f_word = {1'b1, a ^ b};
            NAND:                          f_word = {1'b1, ~(a & b)};
            NOR:                           f_word = {1'b1, ~(a | b)};
            AND_WORD_IMMEDIATE:            f_word = {1'b1, a & s};
            OR_WORD_IMMEDIATE:             f_word = {1'b1, a | s};
            EXCLUSIVE_OR_WORD_IMMEDIATE:   f_word = {1'b1, a ^ s};
            COMPARE_EQUAL_WORD:            f_word = {1'b1, {32{a == b}}};
            COMPARE_EQUAL_WORD_IMMEDIATE:  f_word = {1'b1, {32{a == s}}};
            COMPARE_GREATER_THAN_WORD:     f_word = {1'b1, {32{$signed(a) > $signed(b)}}};
            COMPARE_GREATER_THAN_WORD_IMMEDIATE: f_word = {1'b1, {32{$signed(a) > $signed(s)}}};
            COMPARE_LOGICAL_GREATER_THAN_WORD:   f_word = {1'b1, {32{a > b}}};
            COMPARE_LOGICAL_GREATER_THAN_WORD_IMMEDIATE: f_word = {1'b1, {32{a > s}}};
            COUNT_LEADING_ZEROS:           f_word = {1'b1, 26'd0, f_clz(a)};
            IMMEDIATE_LOAD_HALFWORD:       f_word = {1'b1, i16, i16};
            IMMEDIATE_LOAD_HALFWORD_UPPER: f_word = {1'b1, i16, 16'h0000};
            IMMEDIATE_LOAD_WORD:           f_word = {1'b1, {16{i16[15]}}, i16};
            IMMEDIATE_LOAD_ADDRESS:        f_word = {1'b1, 14'd0, i18};
            SHIFT_LEFT_WORD, SHIFT_LEFT_WORD_IMMEDIATE:
                f_word = {1'b1, cnt[5] ? 32'd0 : (a << cnt[4:0])};
            ROTATE_WORD, ROTATE_WORD_IMMEDIATE:
                f_word = {1'b1, (a << cnt[4:0]) | (a >> (6'd32 - {1'b0, cnt[4:0]}))};
`ifdef EVENPIPE_MULTIPLY_EN
            MULTIPLY, MULTIPLY_AND_ADD:
                f_word = {1'b1, {{16{a[15]}}, a[15:0]} * {{16{b[15]}}, b[15:0]}};
            MULTIPLY_UNSIGNED:             f_word = {1'b1, {16'd0, a[15:0]} * {16'd0, b[15:0]}};
            MULTIPLY_IMMEDIATE:            f_word = {1'b1, {{16{a[15]}}, a[15:0]} * s};
            MULTIPLY_UNSIGNED_IMMEDIATE:   f_word = {1'b1, {16'd0, a[15:0]} * {16'd0, s[15:0]}};
`endif
            default:                       f_word = {1'b0, 32'd0};
        endcase
    endfunction

    function automatic logic [16:0] f_half(input opcode op, input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] s, input logic [4:0] i7);
        logic [4:0] cnt;
        cnt = (op == SHIFT_LEFT_HALFWORD_IMMEDIATE || op == ROTATE_HALFWORD_IMMEDIATE) ? i7 : b[4:0];
        case (op)
            ADD_HALFWORD:                     f_half = {1'b1, a + b};
            ADD_HALFWORD_IMMEDIATE:           f_half = {1'b1, a + s};
            SUBTRACT_FROM_HALFWORD:           f_half = {1'b1, b - a};
            SUBTRACT_FROM_HALFWORD_IMMEDIATE: f_half = {1'b1, s - a};
            AND_HALFWORD_IMMEDIATE:           f_half = {1'b1, a & s};
            OR_HALFWORD_IMMEDIATE:            f_half = {1'b1, a | s};
            EXCLUSIVE_OR_HALFWORD_IMMEDIATE:  f_half = {1'b1, a ^ s};
            COMPARE_EQUAL_HALFWORD:           f_half = {1'b1, {16{a == b}}};
            COMPARE_EQUAL_HALFWORD_IMMEDIATE: f_half = {1'b1, {16{a == s}}};
            COMPARE_GREATER_THAN_HALFWORD:    f_half = {1'b1, {16{$signed(a) > $signed(b)}}};
            COMPARE_GREATER_THAN_HALFWORD_IMMEDIATE: f_half = {1'b1, {16{$signed(a) > $signed(s)}}};
            COMPARE_LOGICAL_GREATER_THAN_HALFWORD:   f_half = {1'b1, {16{a > b}}};
            COMPARE_LOGICAL_GREATER_THAN_HALFWORD_IMMEDIATE: f_half = {1'b1, {16{a > s}}};
            SHIFT_LEFT_HALFWORD, SHIFT_LEFT_HALFWORD_IMMEDIATE:
                f_half = {1'b1, cnt[4] ? 16'd0 : (a << cnt[3:0])};
            ROTATE_HALFWORD, ROTATE_HALFWORD_IMMEDIATE:
                f_half = {1'b1, (a << cnt[3:0]) | (a >> (5'd16 - {1'b0, cnt[3:0]}))};
            default:                          f_half = {1'b0, 16'd0};
        endcase
    endfunction

    opcode        r_op;
    logic [127:0] r_ra;
    logic [127:0] r_rb;
    logic [6:0]   r_rt;
    logic [6:0]   r_i7;
    logic [9:0]   r_i10;
    logic [15:0]  r_i16;
    logic [17:0]  r_i18;
    logic [31:0]  w_s32;
    logic [32:0]  w_fw;
    logic [16:0]  w_fh;
    logic [127:0] w_val;
    logic         w_ok;
    logic         w_unused;

`ifdef EVENPIPE_MULTIPLY_EN
    logic [127:0] r_rc;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rc <= '0;
        else        r_rc <= rc_input;
    end
    assign w_unused = ^{r_i7[6], LATENCY == 2};
`else
    assign w_unused = ^{r_i7[6], LATENCY == 2, rc_input};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op  <= NOP;
            r_ra  <= '0;
            r_rb  <= '0;
            r_rt  <= '0;
            r_i7  <= '0;
            r_i10 <= '0;
            r_i16 <= '0;
            r_i18 <= '0;
        end else begin
            r_op  <= ep_input_op_code;
            r_ra  <= ra_input;
            r_rb  <= rb_input;
            r_rt  <= rt_address_input;
            r_i7  <= I7_input;
            r_i10 <= I10_input;
            r_i16 <= I16_input;
            r_i18 <= I18_input;
        end
    end

    assign w_s32 = {{22{r_i10[9]}}, r_i10};

    // Element loops are index-order agnostic; only the select-mask forms care that word 0 is the MSB word.
    always_comb begin
        w_val = '0;
        w_ok  = 1'b0;
        w_fw  = '0;
        w_fh  = '0;
        for (int i = 0; i < 4; i++) begin
            w_fw = f_word(r_op, r_ra[i*32 +: 32], r_rb[i*32 +: 32], w_s32, r_i16, r_i18, r_i7[5:0]);
`ifdef EVENPIPE_MULTIPLY_EN
            if (r_op == MULTIPLY_AND_ADD) w_fw[31:0] = w_fw[31:0] + r_rc[i*32 +: 32];
`endif
            if (w_fw[32]) begin
                w_ok = 1'b1;
                w_val[i*32 +: 32] = w_fw[31:0];
            end
        end
        for (int j = 0; j < 8; j++) begin
            w_fh = f_half(r_op, r_ra[j*16 +: 16], r_rb[j*16 +: 16], w_s32[15:0], r_i7[4:0]);
            if (w_fh[16]) begin
                w_ok = 1'b1;
                w_val[j*16 +: 16] = w_fh[15:0];
            end
        end
        if (r_op == FORM_SELECT_MASK_FOR_HALFWORDS) begin
            w_ok = 1'b1;
            for (int j = 0; j < 8; j++) w_val[(7-j)*16 +: 16] = {16{r_ra[103-j]}};
        end
        if (r_op == FORM_SELECT_MASK_FOR_WORDS) begin
            w_ok = 1'b1;
            for (int i = 0; i < 4; i++) w_val[(3-i)*32 +: 32] = {32{r_ra[99-i]}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rt_value_output   <= '0;
            rt_address_output <= '0;
            wrt_en_output     <= 1'b0;
        end else begin
            rt_value_output   <= w_ok ? w_val : 128'd0;
            rt_address_output <= r_rt;
            wrt_en_output     <= w_ok;
        end
    end

endmodule

// File: tb/tb_even_pipe.sv
// tb/tb_even_pipe.sv - Table-driven directed bench for even_pipe plus pipelining and flush sequences.
module tb_even_pipe;
    import descriptions::*;

`ifdef EVENPIPE_MULTIPLY_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif
    localparam logic [31:0]  W1 = 32'hFFFF_FFFF;
    localparam logic [127:0] Z  = 128'd0;

    logic         clock = 1'b0;
    logic         reset;
    opcode        op;
    logic [127:0] ra, rb, rc;
    logic [6:0]   rt, i7;
    logic [9:0]   i10;
    logic [15:0]  i16;
    logic [17:0]  i18;
    logic [127:0] rt_value;
    logic [6:0]   rt_addr;
    logic         wrt_en;
    int           n_checks = 0;
    int           n_errors = 0;

    typedef struct {
        opcode        op;
        logic [127:0] ra, rb, rc, ev;
        logic [9:0]   i10;
        logic [15:0]  i16;
        logic [17:0]  i18;
        logic [6:0]   i7;
        logic         een;
    } vec_t;
    vec_t tv[$];

    always #5 clock = ~clock;

    even_pipe dut (
        .clock(clock), .reset(reset), .ep_input_op_code(op),
        .ra_input(ra), .rb_input(rb), .rc_input(rc), .rt_address_input(rt),
        .I7_input(i7), .I10_input(i10), .I16_input(i16), .I18_input(i18),
        .rt_value_output(rt_value), .rt_address_output(rt_addr), .wrt_en_output(wrt_en)
    );

    function automatic vec_t mk(input opcode o, input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] c, input logic [9:0] x10, input logic [15:0] x16,
                                input logic [17:0] x18, input logic [6:0] x7, input logic [127:0] e,
                                input logic en);
        vec_t v;
        v.op = o; v.ra = a; v.rb = b; v.rc = c; v.i10 = x10; v.i16 = x16; v.i18 = x18; v.i7 = x7;
        v.ev = e; v.een = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [6:0] addr);
        op = v.op; ra = v.ra; rb = v.rb; rc = v.rc;
        i10 = v.i10; i16 = v.i16; i18 = v.i18; i7 = v.i7; rt = addr;
    endtask

    initial begin
        reset = 1'b0;
        drive(mk(NOP, Z, Z, Z, 0, 0, 0, 0, Z, 0), 7'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset value", rt_value, Z);
        chk("reset addr", {121'd0, rt_addr}, Z);
        chk("reset wrt_en", {127'd0, wrt_en}, Z);
        @(negedge clock);
        reset = 1'b1;

        tv.push_back(mk(ADD_WORD, 128'd20, 128'd10, Z, 0, 0, 0, 0, 128'd30, 1));
        tv.push_back(mk(SUBTRACT_FROM_WORD_IMMEDIATE, 128'd25, Z, Z, 10'd100, 0, 0, 0, {32'd100, 32'd100, 32'd100, 32'd75}, 1));
        tv.push_back(mk(SUBTRACT_FROM_WORD, 128'd20, 128'd55, Z, 0, 0, 0, 0, 128'd35, 1));
        tv.push_back(mk(COMPARE_EQUAL_WORD, 128'd234, 128'd235, Z, 0, 0, 0, 0, {W1, W1, W1, 32'd0}, 1));
        tv.push_back(mk(COUNT_LEADING_ZEROS, 128'd1025, Z, Z, 0, 0, 0, 0, {32'd32, 32'd32, 32'd32, 32'd21}, 1));
        tv.push_back(mk(COUNT_LEADING_ZEROS, {32'd0, W1, 32'd1, 32'h0001_0000}, Z, Z, 0, 0, 0, 0, {32'd32, 32'd0, 32'd31, 32'd15}, 1));
        tv.push_back(mk(IMMEDIATE_LOAD_ADDRESS, Z, Z, Z, 0, 0, 18'd2348, 0, {4{32'h0000_092C}}, 1));
        tv.push_back(mk(SHIFT_LEFT_WORD, 128'd213, 128'd2, Z, 0, 0, 0, 0, 128'd852, 1));
        tv.push_back(mk(ADD_HALFWORD, {4{32'h7FFF_0001}}, {4{32'h0001_FFFF}}, Z, 0, 0, 0, 0, {4{32'h8000_0000}}, 1));
        tv.push_back(mk(ADD_HALFWORD_IMMEDIATE, {8{16'h0005}}, Z, Z, 10'h3FE, 0, 0, 0, {8{16'h0003}}, 1));
        tv.push_back(mk(SUBTRACT_FROM_HALFWORD, {8{16'h0001}}, Z, Z, 0, 0, 0, 0, {8{16'hFFFF}}, 1));
        tv.push_back(mk(SUBTRACT_FROM_HALFWORD_IMMEDIATE, {8{16'h8000}}, Z, Z, 10'd0, 0, 0, 0, {8{16'h8000}}, 1));
        tv.push_back(mk(CARRY_GENERATE, {W1, 32'd1, 32'h8000_0000, 32'd0}, {32'd1, 32'd1, 32'h8000_0000, 32'd0}, Z, 0, 0, 0, 0, {32'd1, 32'd0, 32'd1, 32'd0}, 1));
        tv.push_back(mk(BORROW_GENERATE, {32'd5, 32'd6, 32'd0, W1}, {32'd5, 32'd5, 32'd0, 32'd0}, Z, 0, 0, 0, 0, {32'd1, 32'd0, 32'd1, 32'd0}, 1));
        tv.push_back(mk(COMPARE_GREATER_THAN_WORD, {W1, 32'd1, 32'h8000_0000, 32'd5}, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'd5}, Z, 0, 0, 0, 0, {32'd0, W1, 32'd0, 32'd0}, 1));
        tv.push_back(mk(COMPARE_LOGICAL_GREATER_THAN_WORD, {W1, 32'd1, 32'h8000_0000, 32'd5}, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'd5}, Z, 0, 0, 0, 0, {W1, W1, W1, 32'd0}, 1));
        tv.push_back(mk(COMPARE_EQUAL_HALFWORD_IMMEDIATE, {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 48'd0, 16'hFFFF}, Z, Z, 10'h3FF, 0, 0, 0, {16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 48'd0, 16'hFFFF}, 1));
        tv.push_back(mk(COMPARE_GREATER_THAN_HALFWORD_IMMEDIATE, {16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 64'd0}, Z, Z, 10'd0, 0, 0, 0, {16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 64'd0}, 1));
        tv.push_back(mk(NAND, {4{32'hF0F0_F0F0}}, {4{32'hFF00_FF00}}, Z, 0, 0, 0, 0, {4{32'h0FFF_0FFF}}, 1));
        tv.push_back(mk(OR_COMPLEMENT, {4{32'h0000_00F0}}, {4{32'hFFFF_FF00}}, Z, 0, 0, 0, 0, {4{32'h0000_00FF}}, 1));
        tv.push_back(mk(AND_WITH_COMPLEMENT, {4{32'hFFFF_0000}}, {4{32'h0F0F_0F0F}}, Z, 0, 0, 0, 0, {4{32'hF0F0_0000}}, 1));
        tv.push_back(mk(EXCLUSIVE_OR_WORD_IMMEDIATE, {4{32'h1234_5678}}, Z, Z, 10'h200, 0, 0, 0, {4{32'hEDCB_A878}}, 1));
        tv.push_back(mk(OR_HALFWORD_IMMEDIATE, {8{16'h0010}}, Z, Z, 10'd3, 0, 0, 0, {8{16'h0013}}, 1));
        tv.push_back(mk(FORM_SELECT_MASK_FOR_HALFWORDS, {32'h0000_00A1, {3{W1}}}, Z, Z, 0, 0, 0, 0, {16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 48'd0, 16'hFFFF}, 1));
        tv.push_back(mk(FORM_SELECT_MASK_FOR_WORDS, {32'hABCD_EF06, {3{W1}}}, Z, Z, 0, 0, 0, 0, {32'd0, W1, W1, 32'd0}, 1));
        tv.push_back(mk(SHIFT_LEFT_WORD_IMMEDIATE, {4{32'd3}}, Z, Z, 0, 0, 0, 7'd31, {4{32'h8000_0000}}, 1));
        tv.push_back(mk(SHIFT_LEFT_WORD_IMMEDIATE, {4{32'd3}}, Z, Z, 0, 0, 0, 7'd32, Z, 1));
        tv.push_back(mk(SHIFT_LEFT_HALFWORD, {8{16'h0001}}, {16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd31, 16'd32, 16'd5}, Z, 0, 0, 0, 0, {16'h0001, 16'h0002, 16'h8000, 48'd0, 16'h0001, 16'h0020}, 1));
        tv.push_back(mk(ROTATE_WORD, {4{32'h8000_0001}}, {32'd0, 32'd1, 32'd32, 32'd33}, Z, 0, 0, 0, 0, {32'h8000_0001, 32'h3, 32'h8000_0001, 32'h3}, 1));
        tv.push_back(mk(ROTATE_HALFWORD_IMMEDIATE, {8{16'h1234}}, Z, Z, 0, 0, 0, 7'd4, {8{16'h2341}}, 1));
        tv.push_back(mk(IMMEDIATE_LOAD_HALFWORD, Z, Z, Z, 0, 16'hABCD, 0, 0, {8{16'hABCD}}, 1));
        tv.push_back(mk(IMMEDIATE_LOAD_HALFWORD_UPPER, Z, Z, Z, 0, 16'hABCD, 0, 0, {4{32'hABCD_0000}}, 1));
        tv.push_back(mk(IMMEDIATE_LOAD_WORD, Z, Z, Z, 0, 16'h8001, 0, 0, {4{32'hFFFF_8001}}, 1));
        tv.push_back(mk(MULTIPLY, 128'd64, 128'd128, Z, 0, 0, 0, 0, MUL ? 128'd8192 : Z, MUL));
        tv.push_back(mk(MULTIPLY, {4{32'h0000_FFFF}}, {4{32'd2}}, Z, 0, 0, 0, 0, MUL ? {4{32'hFFFF_FFFE}} : Z, MUL));
        tv.push_back(mk(MULTIPLY_UNSIGNED, {4{32'h0000_FFFF}}, {4{32'd2}}, Z, 0, 0, 0, 0, MUL ? {4{32'h0001_FFFE}} : Z, MUL));
        tv.push_back(mk(MULTIPLY_IMMEDIATE, {4{32'd3}}, Z, Z, 10'h3FD, 0, 0, 0, MUL ? {4{32'hFFFF_FFF7}} : Z, MUL));
        tv.push_back(mk(MULTIPLY_UNSIGNED_IMMEDIATE, {4{32'd2}}, Z, Z, 10'h3FF, 0, 0, 0, MUL ? {4{32'h0001_FFFE}} : Z, MUL));
        tv.push_back(mk(MULTIPLY_AND_ADD, {4{32'h0000_FFFF}}, {4{32'd5}}, {4{32'd10}}, 0, 0, 0, 0, MUL ? {4{32'd5}} : Z, MUL));
        tv.push_back(mk(FLOATING_MULTIPLY, 128'd64, 128'd128, Z, 0, 0, 0, 0, Z, 0));
        tv.push_back(mk(LOAD_QUADWORD, 128'd64, 128'd128, Z, 0, 0, 0, 0, Z, 0));

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clock);
            drive(tv[k], 7'(k + 1));
            @(posedge clock);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d %s value", k, tv[k].op.name()), rt_value, tv[k].ev);
            chk($sformatf("vec%0d wrt_en", k), {127'd0, wrt_en}, {127'd0, tv[k].een});
            if (tv[k].een) chk($sformatf("vec%0d addr", k), {121'd0, rt_addr}, {121'd0, 7'(k + 1)});
        end

        // Back-to-back issue: each result appears one cycle after the previous one.
        @(negedge clock);
        drive(mk(AND, 128'd2, 128'd8, Z, 0, 0, 0, 0, Z, 1), 7'd10);
        @(negedge clock);
        drive(mk(OR, 128'd2, 128'd4, Z, 0, 0, 0, 0, Z, 1), 7'd11);
        @(posedge clock);
        #1;
        chk("b2b AND value", rt_value, Z);
        chk("b2b AND wrt_en", {127'd0, wrt_en}, 128'd1);
        chk("b2b AND addr", {121'd0, rt_addr}, 128'd10);
        @(negedge clock);
        drive(mk(NOP, Z, Z, Z, 0, 0, 0, 0, Z, 0), 7'd0);
        @(posedge clock);
        #1;
        chk("b2b OR value", rt_value, 128'd6);
        chk("b2b OR wrt_en", {127'd0, wrt_en}, 128'd1);
        chk("b2b OR addr", {121'd0, rt_addr}, 128'd11);

        // Mid-flight reset: outputs clear at once and the op in stage 1 never emerges.
        @(negedge clock);
        drive(mk(AND, 128'd2, 128'd8, Z, 0, 0, 0, 0, Z, 1), 7'd12);
        @(negedge clock);
        drive(mk(OR, 128'd2, 128'd4, Z, 0, 0, 0, 0, Z, 1), 7'd13);
        @(posedge clock);
        #1;
        chk("flush pre AND wrt_en", {127'd0, wrt_en}, 128'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("flush async value", rt_value, Z);
        chk("flush async wrt_en", {127'd0, wrt_en}, Z);
        chk("flush async addr", {121'd0, rt_addr}, Z);
        @(negedge clock);
        drive(mk(NOP, Z, Z, Z, 0, 0, 0, 0, Z, 0), 7'd0);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("flush post%0d wrt_en", c), {127'd0, wrt_en}, Z);
            chk($sformatf("flush post%0d value", c), rt_value, Z);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
